// File: rtl/seven_segment_pkg.sv
// seven_segment_pkg: segment bit indices and the active-high hex glyph set.
package seven_segment_pkg;
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;
  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;
  localparam logic [15:0][6:0] GLYPHS = {
    GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
    GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
  };
endpackage

// File: rtl/seven_segment_pattern_decoder.sv
// seven_segment_pattern_decoder: maps an active-high a..g pattern to its hex value.
module seven_segment_pattern_decoder
  import seven_segment_pkg::*;
(
  input  logic [6:0] segments,
  output logic [3:0] value,
  output logic       match
);
  always_comb begin
    value = '0;
    match = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (segments == GLYPHS[i]) begin
        value = 4'(i);
        match = 1'b1;
      end
    end
  end
endmodule

// File: rtl/seven_segment_scan_decoder.sv
// seven_segment_scan_decoder: rebuilds the hex word shown on a multiplexed active-low display bus.
module seven_segment_scan_decoder
  import seven_segment_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [7:0]              segmentEnableN,
  input  logic [NUM_DIGITS-1:0]   digitEnableN,
  output logic [NUM_DIGITS*4-1:0] data,
  output logic [NUM_DIGITS-1:0]   pointEnable,
  output logic                    frameValid,
  output logic                    decodeError,
  output logic                    stale
);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_ARM = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] SETTLE_MAX = 8'(STABLE_CYCLES);
  logic [7:0] seg_meta, seg_sync, seg_q;
  logic [NUM_DIGITS-1:0] dig_meta, dig_sync, dig_q;
  logic [7:0] settle;
  logic armed;
  logic [WD_W-1:0] wd;
  logic [NUM_DIGITS-1:0] seen, shadow_dp, active;
  logic [NUM_DIGITS*4-1:0] shadow_data;
  logic [IDX_W-1:0] idx;
  logic [3:0] value;
  logic match, changed, settled, one_hot, hit, capture, full, wd_expire;
  seven_segment_pattern_decoder u_decoder (
    .segments(~seg_q[SEG_G:SEG_A]),
    .value   (value),
    .match   (match)
  );
  assign changed   = {seg_sync, dig_sync} != {seg_q, dig_q};
  assign settled   = armed && settle == SETTLE_MAX;
  assign active    = ~dig_q;
  assign one_hot   = active != '0 && (active & (active - NUM_DIGITS'(1))) == '0;
  assign hit       = settled && one_hot;
  assign capture   = hit && match;
  assign full      = &seen;
  assign stale     = wd == WD_MAX;
  assign wd_expire = !hit && wd == WD_ARM;
  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) idx = active[i] ? IDX_W'(i) : idx;
  end
  // settle holds how many consecutive cycles the current sample has been present
  always_ff @(posedge clock) begin
    if (reset) begin
      seg_meta    <= '1;
      seg_sync    <= '1;
      seg_q       <= '1;
      dig_meta    <= '1;
      dig_sync    <= '1;
      dig_q       <= '1;
      settle      <= '0;
      armed       <= 1'b1;
      wd          <= '0;
      seen        <= '0;
      shadow_data <= '0;
      shadow_dp   <= '0;
      data        <= '0;
      pointEnable <= '0;
      frameValid  <= 1'b0;
      decodeError <= 1'b0;
    end else begin
      seg_meta    <= segmentEnableN;
      seg_sync    <= seg_meta;
      seg_q       <= seg_sync;
      dig_meta    <= digitEnableN;
      dig_sync    <= dig_meta;
      dig_q       <= dig_sync;
      settle      <= changed ? 8'd1 : (settle == SETTLE_MAX ? settle : settle + 8'd1);
      armed       <= changed ? 1'b1 : (settled ? 1'b0 : armed);
      wd          <= hit ? '0 : (stale ? wd : wd + WD_W'(1));
      decodeError <= hit && !match;
      frameValid  <= full;
      seen        <= ((full || wd_expire) ? '0 : seen) | (capture ? NUM_DIGITS'(1) << idx : '0);
      if (full) begin
        data        <= shadow_data;
        pointEnable <= shadow_dp;
      end
      if (capture) begin
        shadow_data[idx*4 +: 4] <= value;
        shadow_dp[idx]          <= ~seg_q[SEG_DP];
      end
    end
  end
endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// tb_seven_segment_scan_decoder: directed and random scans checked against a frame-level model.
module tb_seven_segment_scan_decoder;
  localparam int ND = 4;
  localparam int ST = 4;
  localparam int TO = 50;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] seg_n = '1;
  logic [ND-1:0] dig_n = '1;
  logic [ND*4-1:0] data;
  logic [ND-1:0] pe;
  logic fv, de, stale;
  seven_segment_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(ST), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clk), .reset(rst), .segmentEnableN(seg_n), .digitEnableN(dig_n),
    .data(data), .pointEnable(pe), .frameValid(fv), .decodeError(de), .stale(stale)
  );
  always #5 clk = ~clk;
  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int cyc = 0;
  int n_frames = 0, n_errs = 0, frame_edge = -1, stale_edge = -1;
  logic stale_q = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (fv) begin
      n_frames   <= n_frames + 1;
      frame_edge <= cyc;
    end
    if (de) n_errs <= n_errs + 1;
    if (stale && !stale_q) stale_edge <= cyc;
    stale_q <= stale;
  end
  logic [ND*4-1:0] m_shadow = '0, m_data = '0;
  logic [ND-1:0] m_shadow_dp = '0, m_seen = '0, m_pe = '0;
  int m_frames = 0, m_errs = 0, since_cap = 0;
  int n_checks = 0, n_fail = 0;
  int t0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [7:0] s, input logic [ND-1:0] d, input int n);
    seg_n = s;
    dig_n = d;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    since_cap += n;
    put('1, '1, n);
  endtask

  // a pattern held for at least ST cycles on exactly one digit is captured
  task automatic step(input logic [6:0] seg7, input logic dp, input logic [ND-1:0] mask, input int n);
    int k, v;
    if (n >= ST && $countones(mask) == 1) begin
      k = 0;
      v = -1;
      for (int i = 0; i < ND; i++) if (mask[i]) k = i;
      for (int g = 0; g < 16; g++) if (glyph[g] == seg7) v = g;
      since_cap = 0;
      if (v < 0) m_errs++;
      else begin
        m_shadow[k*4 +: 4] = 4'(v);
        m_shadow_dp[k] = dp;
        m_seen[k] = 1'b1;
        if (&m_seen) begin
          m_frames++;
          m_data = m_shadow;
          m_pe = m_shadow_dp;
          m_seen = '0;
        end
      end
    end else since_cap += n;
    put(~{dp, seg7}, ~mask, n);
  endtask

  task automatic show(input int k, input int v, input logic dp, input int n);
    step(glyph[v], dp, ND'(1) << k, n);
  endtask

  task automatic verify(input string tag);
    idle(10);
    check({tag, "_frames"}, n_frames, m_frames);
    check({tag, "_errors"}, n_errs, m_errs);
    check({tag, "_data"}, data, m_data);
    check({tag, "_point"}, pe, m_pe);
    check({tag, "_stale"}, stale, 1'b0);
  endtask

  task automatic model_reset();
    m_shadow = '0;
    m_shadow_dp = '0;
    m_seen = '0;
    m_data = '0;
    m_pe = '0;
  endtask

  initial begin
    int kind, n;
    logic [ND-1:0] mask;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", data, 0);
    check("rst_point", pe, 0);
    check("rst_frame", fv, 0);
    check("rst_error", de, 0);
    check("rst_stale", stale, 0);
    rst = 1'b0;
    show(0, 1, 0, 10);
    show(1, 2, 0, 10);
    show(2, 3, 0, 10);
    t0 = cyc;
    show(3, 4, 0, 10);
    check("frame_latency", (frame_edge - t0 >= ST + 3) && (frame_edge - t0 <= ST + 4), 1);
    verify("scan");
    check("scan_word", data, 16'h4321);
    show(0, 1, 0, 10);
    show(1, 2, 0, 10);
    show(2, 3, 0, 3);
    show(3, 4, 0, 10);
    verify("short");
    check("short_noframe", n_frames, 1);
    show(0, 9, 0, 10);
    show(1, 10, 1, 10);
    show(2, 11, 0, 10);
    verify("short_done");
    check("short_word", data, 16'h4BA9);
    show(0, 5, 0, 10);
    step(7'h41, 1'b0, 4'b0010, 10);
    show(2, 6, 0, 10);
    show(3, 7, 0, 10);
    verify("bad");
    check("bad_pulse", n_errs, 1);
    show(1, 8, 1, 10);
    verify("bad_done");
    check("bad_word", data, 16'h7685);
    step(glyph[3], 1'b0, 4'b0110, 10);
    step(glyph[3], 1'b0, 4'b0000, 10);
    verify("multi");
    show(0, 12, 1, 10);
    show(1, 13, 0, 10);
    show(2, 14, 0, 10);
    show(3, 15, 1, 10);
    verify("multi_done");
    check("multi_word", {pe, data}, {4'b1001, 16'hFEDC});
    show(0, 2, 0, 10);
    t0 = cyc;
    show(1, 3, 0, 10);
    idle(40);
    check("stale_early", stale, 0);
    idle(15);
    check("stale_set", stale, 1);
    check("stale_latency", (stale_edge - t0 >= ST + 2 + TO) && (stale_edge - t0 <= ST + 3 + TO), 1);
    m_seen = '0;
    show(2, 4, 0, 10);
    show(3, 5, 0, 10);
    verify("stale_partial");
    show(0, 6, 0, 10);
    show(1, 7, 0, 10);
    verify("stale_done");
    check("stale_word", data, 16'h5476);
    show(0, 1, 0, 10);
    show(1, 1, 0, 10);
    show(2, 1, 0, 10);
    idle(10);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check("mid_rst_data", data, 0);
    check("mid_rst_point", pe, 0);
    check("mid_rst_frame", fv, 0);
    show(0, 3, 0, 10);
    show(1, 5, 0, 10);
    show(2, 7, 0, 10);
    verify("post_rst_partial");
    show(3, 9, 0, 10);
    verify("post_rst");
    check("post_rst_word", data, 16'h9753);
    for (int s = 0; s < 200; s++) begin
      idle(1);
      kind = $urandom_range(0, 99);
      n = ($urandom_range(0, 4) == 0) ? $urandom_range(1, ST - 1) : $urandom_range(ST, 9);
      if (since_cap > 20) show($urandom_range(0, ND - 1), $urandom_range(0, 15), 1'($urandom), 6);
      else if (kind < 10) step(7'($urandom), 1'($urandom), '0, n);
      else if (kind < 18) begin
        do mask = ND'($urandom); while ($countones(mask) < 2);
        step(7'($urandom), 1'($urandom), mask, n);
      end
      else if (kind < 28) step(7'($urandom), 1'($urandom), ND'(1) << $urandom_range(0, ND - 1), n);
      else show($urandom_range(0, ND - 1), $urandom_range(0, 15), 1'($urandom), n);
      if (s % 20 == 19) verify("random");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
